// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - shared PRBS31 constants and checker state type
// Used by the checker and by the PRBS31 generator.
// Contents: PRBS_LEN (register length), TAP_A/TAP_B (feedback taps for x^31+x^28+1),
//           prbs_state_e (HUNT, VERIFY, LOCKED).
package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 30;
    localparam int TAP_B    = 27;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

endpackage

// File: rtl/prbs31_lfsr_step.sv
// rtl/prbs31_lfsr_step.sv - combinational PRBS31 predict-and-shift step
// Ports:
//   sr       in  current 31-bit register, sr[0] holds the newest bit
//   din      in  received bit, shifted in when flywheel=0
//   flywheel in  1: shift in the predicted bit instead of din
//   pred     out predicted next bit, sr[TAP_A] ^ sr[TAP_B]
//   sr_next  out register after one shift
module prbs31_lfsr_step
    import prbs31_pkg::*;
(
    input  logic [PRBS_LEN-1:0] sr,
    input  logic                din,
    input  logic                flywheel,
    output logic                pred,
    output logic [PRBS_LEN-1:0] sr_next
);

    always_comb begin
        pred    = sr[TAP_A] ^ sr[TAP_B];
        sr_next = {sr[PRBS_LEN-2:0], (flywheel ? (sr[TAP_A] ^ sr[TAP_B]) : din)};
    end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 (x^31+x^28+1) serial checker with lock tracking
// Parameters: LOCK_CNT (matches to lock), WIN (error window length, valid bits),
//             LOSS_THRESH (errors per window forcing loss), CNT_W (err_count width)
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous reset, active-high
//   din        in  received serial bit
//   din_valid  in  qualifies din
//   clr_err    in  synchronous clear of err_count
//   locked     out high while in LOCKED
//   err        out one-cycle pulse per mismatched bit while locked
//   err_count  out saturating count of locked-state bit errors
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int WIN         = 128,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int FW = $clog2(PRBS_LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(PRBS_LEN - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
    localparam logic [EW-1:0] THR_LAST   = EW'(LOSS_THRESH - 1);

    prbs_state_e         state, state_n;
    logic [PRBS_LEN-1:0] sr, sr_n, sr_step;
    logic [FW-1:0]       fill, fill_n;
    logic [MW-1:0]       match, match_n;
    logic [WW-1:0]       win_cnt, win_cnt_n;
    logic [EW-1:0]       win_err, win_err_n;
    logic                locked_n, err_n;
    logic [CNT_W-1:0]    err_count_n;
    logic                pred, mismatch, err_hit;

    // In LOCKED the register free-runs on its own prediction, so corrupted
    // received bits cannot poison the reference.
    prbs31_lfsr_step u_step (
        .sr       (sr),
        .din      (din),
        .flywheel (state == LOCKED),
        .pred     (pred),
        .sr_next  (sr_step)
    );

    assign mismatch = din ^ pred;
    assign err_hit  = din_valid && (state == LOCKED) && mismatch;

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        fill_n      = fill;
        match_n     = match;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_count_n = err_count;

        if (din_valid) begin
            sr_n = sr_step;
            case (state)
                HUNT: begin
                    if (fill == FILL_LAST) begin
                        fill_n  = '0;
                        match_n = '0;
                        // An all-zero fill is the LFSR lock-up state; keep hunting.
                        if (sr_step != '0) begin
                            state_n = VERIFY;
                        end
                    end else begin
                        fill_n = fill + FW'(1);
                    end
                end
                VERIFY: begin
                    if (mismatch || (sr_step == '0)) begin
                        state_n = HUNT;
                        fill_n  = '0;
                    end else if (match == MATCH_LAST) begin
                        state_n   = LOCKED;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        match_n = match + MW'(1);
                    end
                end
                LOCKED: begin
                    // win_err compared before increment: THR_LAST plus this error reaches the threshold.
                    if (mismatch && (win_err >= THR_LAST)) begin
                        state_n   = HUNT;
                        fill_n    = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WW'(1);
                        win_err_n = win_err + EW'(mismatch);
                    end
                end
                default: begin
                    state_n = HUNT;
                    fill_n  = '0;
                end
            endcase
        end

        // A clear coinciding with an error leaves that error counted.
        if (clr_err) begin
            err_count_n = err_hit ? CNT_W'(1) : '0;
        end else if (err_hit && (err_count != '1)) begin
            err_count_n = err_count + CNT_W'(1);
        end

        locked_n = (state_n == LOCKED);
        err_n    = err_hit;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            fill      <= fill_n;
            match     <= match_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            locked    <= locked_n;
            err       <= err_n;
            err_count <= err_count_n;
        end
    end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64, which sets the consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter WIN, default 128, which sets the length in valid bits of the loss-of-lock error window.
REQ-003 SHALL have parameter LOSS_THRESH, default 8, which sets the errors within one window that force loss of lock.
REQ-004 SHALL have parameter CNT_W, default 16, which sets the err_count width.
REQ-005 SHALL have clk, input, 1 bit, the clock; all logic on rising edge.
REQ-006 SHALL have rst_n, input, 1 bit, the reset: asynchronous, active-high; clock clk.
REQ-007 SHALL have din, input, 1 bit, the received serial PRBS31 bit.
REQ-008 SHALL have din_valid, input, 1 bit, which qualifies din; the bit is consumed only on a cycle where this is 1.
REQ-009 SHALL have clr_err, input, 1 bit, a synchronous clear of err_count.
REQ-010 SHALL have locked, output, 1 bit, high while in state LOCKED.
REQ-011 SHALL have err, output, 1 bit, a one-cycle pulse per mismatched bit while locked.
REQ-012 SHALL have err_count, output, CNT_W bits, the saturating count of bit errors.

Function
REQ-013 SHALL check polynomial x^31+x^28+1: 31-bit shift register sr, new bit into sr[0], predicted bit p = sr[30] XOR sr[27].
REQ-014 SHALL implement state HUNT: each valid din shifts into sr and fill_cnt increments; after 31 valid bits, move to VERIFY with match_cnt=0.
REQ-015 SHALL implement state VERIFY: each valid din shifts into sr; if din==p, match_cnt increments; when match_cnt reaches LOCK_CNT, move to LOCKED.
REQ-016 SHALL, on a din!=p in VERIFY, return to HUNT with fill_cnt=0; err is not pulsed and err_count is not changed.
REQ-017 SHALL apply a zero-lock guard: if sr is all-zero on entry to VERIFY or on a match in VERIFY, return to HUNT instead of progressing.
REQ-018 SHALL run state LOCKED as a flywheel: sr shifts in p, not din, on each valid bit, so received errors do not corrupt the reference.
REQ-019 SHALL, on a valid bit with din!=p in LOCKED, register err=1 for exactly one cycle (latency 1 clk after the sampling edge) and increment err_count.
REQ-020 SHALL keep win_cnt (0..WIN-1) and win_err counters in LOCKED; on the WIN-th valid bit, both reset to 0.
REQ-021 SHALL, when win_err including the current bit reaches LOSS_THRESH, move to HUNT on that edge, deassert locked, and set fill_cnt, win_cnt and win_err to 0.
REQ-022 SHALL count only LOCKED-state errors in err_count, which saturates at 2^CNT_W-1 and never wraps.
REQ-023 SHALL clear err_count to 0 on clr_err; if clr_err and an error occur in the same cycle, err_count becomes 1.
REQ-024 SHALL hold all state, sr and counters on cycles where din_valid=0, with err=0.
REQ-025 SHALL register all outputs; locked rises on the clock edge that consumes the LOCK_CNT-th match.

Reset
REQ-026 SHALL, on rst_n=1, asynchronously force state=HUNT, sr=0, all internal counters 0, locked=0, err=0, err_count=0.
REQ-027 SHALL, when reset arrives mid-lock, drop lock immediately; after release, a full 31+LOCK_CNT valid bits are required to relock.

Structure
REQ-028 SHALL place the state enum (HUNT, VERIFY, LOCKED), PRBS_LEN=31 and the tap constants TAP_A=30 and TAP_B=27 in shared package prbs31_pkg, also used by the generator.
REQ-029 SHALL place the next-bit/shift step in sub-module prbs31_lfsr_step, which is combinational and shared with the PRBS31 generator.

Verification
REQ-030 SHALL verify clean lock: generator seed 0x7FFFFFFF, din_valid=1 continuous -> locked rises after the 95th bit; 10,000 further bits give err_count=0.
REQ-031 SHALL verify a single error: while locked, invert bit 500 -> one err pulse one cycle later, err_count=1, locked stays 1.
REQ-032 SHALL verify loss of lock: while locked, invert 8 bits within 100 bits -> locked falls on the 8th error edge, err_count=8, relock after 95 further clean bits.
REQ-033 SHALL verify zero lock-up rejection: din=0 for 1,000 valid bits -> locked never asserts, err_count=0.
REQ-034 SHALL verify saturation and clear: CNT_W=4 with 20 isolated errors -> err_count=15; clr_err together with an error -> err_count=1.
REQ-035 SHALL verify gaps and reset: random din_valid=0 gaps -> same lock point in valid-bit count; rst_n pulse while locked -> locked=0 and err_count=0 immediately.
